// File: rtl/vid_timing_gen_pkg.sv
// Shared types, region helpers and colour-bar table for vid_timing_gen.
// Optional colour-bar generator is enabled with TEST_PATTERN_EN.
package vid_timing_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Region boundaries; the active end value is exclusive
  function automatic int region_total(int s, int bp, int a, int fp);
    return s + bp + a + fp;
  endfunction

  function automatic int act_start(int s, int bp);
    return s + bp;
  endfunction

  function automatic int act_end(int s, int bp, int a);
    return s + bp + a;
  endfunction

  // {R,G,B} on/off per bar; bar 0 sits in the low bits
  localparam logic [23:0] BAR_TBL = {
    3'b000, 3'b001, 3'b100, 3'b101,
    3'b010, 3'b011, 3'b110, 3'b111
  };

  function automatic logic [2:0] bar_rgb(logic [2:0] idx);
    return BAR_TBL[int'(idx)*3 +: 3];
  endfunction

endpackage

// File: rtl/vid_sync_cnt.sv
// Horizontal/vertical position counters and region decode.
// Counters sit at zero whenever run is low.
module vid_sync_cnt
  import vid_timing_gen_pkg::*;
#(
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int CNT_W    = 12
) (
  input  logic             clk1x,
  input  logic             rst,
  input  logic             run,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             hs,
  output logic             vs,
  output logic             act
);

  localparam logic [CNT_W-1:0] H_LAST =
    CNT_W'(region_total(H_SYNC, H_BP, H_ACTIVE, H_FP) - 1);
  localparam logic [CNT_W-1:0] V_LAST =
    CNT_W'(region_total(V_SYNC, V_BP, V_ACTIVE, V_FP) - 1);
  localparam logic [CNT_W-1:0] H_SY = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SY = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_AS = CNT_W'(act_start(H_SYNC, H_BP));
  localparam logic [CNT_W-1:0] H_AE =
    CNT_W'(act_end(H_SYNC, H_BP, H_ACTIVE));
  localparam logic [CNT_W-1:0] V_AS = CNT_W'(act_start(V_SYNC, V_BP));
  localparam logic [CNT_W-1:0] V_AE =
    CNT_W'(act_end(V_SYNC, V_BP, V_ACTIVE));

  logic h_act;
  logic v_act;

  always_ff @(posedge clk1x) begin
    if (rst || !run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign h_act = (h_cnt >= H_AS) && (h_cnt < H_AE);
  assign v_act = (v_cnt >= V_AS) && (v_cnt < V_AE);
  assign hs    = run && (h_cnt < H_SY);
  assign vs    = run && (v_cnt < V_SY);
  assign act   = run && h_act && v_act;

endmodule

// File: rtl/vid_timing_gen.sv
// Parametrised video timing generator with FIFO pixel path and underflow tracking.
// Define TEST_PATTERN_EN to add pat_sel and the 8-bar colour generator.
module vid_timing_gen
  import vid_timing_gen_pkg::*;
#(
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int COLOR_W  = 8,
  parameter int CNT_W    = 12
) (
  input  logic                 clk1x,
  input  logic                 rst,
  input  logic                 en,
  input  logic [3*COLOR_W-1:0] rgb_pixel,
  input  logic                 fifo_empty,
`ifdef TEST_PATTERN_EN
  input  logic                 pat_sel,
`endif
  output logic                 rd_start,
  output logic                 rd_fifo_en,
  output logic [COLOR_W-1:0]   po_vga_r,
  output logic [COLOR_W-1:0]   po_vga_g,
  output logic [COLOR_W-1:0]   po_vga_b,
  output logic                 po_de,
  output logic                 po_h_sync,
  output logic                 po_v_sync,
  output logic                 underflow,
  output logic [15:0]          underflow_cnt
);

  localparam logic [CNT_W-1:0] H_LAST =
    CNT_W'(region_total(H_SYNC, H_BP, H_ACTIVE, H_FP) - 1);
  localparam logic [CNT_W-1:0] V_LAST =
    CNT_W'(region_total(V_SYNC, V_BP, V_ACTIVE, V_FP) - 1);
  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  state_t               state;
  logic [CNT_W-1:0]     h_cnt;
  logic [CNT_W-1:0]     v_cnt;
  logic                 hs;
  logic                 vs;
  logic                 act;
  logic                 frame_end;
  logic                 hs1;
  logic                 vs1;
  logic                 act1;
  logic [3*COLOR_W-1:0] rgb;

  vid_sync_cnt #(
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .CNT_W    (CNT_W)
  ) u_cnt (
    .clk1x (clk1x),
    .rst   (rst),
    .run   (state == RUN),
    .h_cnt (h_cnt),
    .v_cnt (v_cnt),
    .hs    (hs),
    .vs    (vs),
    .act   (act)
  );

  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

`ifdef TEST_PATTERN_EN
  localparam logic [CNT_W-1:0] H_AS = CNT_W'(act_start(H_SYNC, H_BP));
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);

  logic             pat_mode;
  logic [CNT_W-1:0] bar_pix;
  logic [2:0]       bar_idx;
  logic [2:0]       bar_c;

  // bar_pix/bar_idx describe the pixel the counters held one cycle ago
  always_ff @(posedge clk1x) begin
    if (rst) begin
      bar_pix <= '0;
      bar_idx <= '0;
    end else if (h_cnt == H_AS) begin
      bar_pix <= '0;
      bar_idx <= '0;
    end else if (bar_pix == BAR_LAST) begin
      bar_pix <= '0;
      bar_idx <= bar_idx + 1'b1;
    end else begin
      bar_pix <= bar_pix + 1'b1;
    end
  end

  assign bar_c = bar_rgb(bar_idx);
`endif

  always_ff @(posedge clk1x) begin
    if (rst) begin
      state    <= IDLE;
      rd_start <= 1'b0;
`ifdef TEST_PATTERN_EN
      pat_mode <= 1'b0;
`endif
    end else begin
      rd_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en) begin
            state    <= RUN;
            rd_start <= 1'b1;
`ifdef TEST_PATTERN_EN
            pat_mode <= pat_sel;
`endif
          end
        end
        RUN: begin
          if (frame_end) begin
            if (en) begin
              rd_start <= 1'b1;
`ifdef TEST_PATTERN_EN
              pat_mode <= pat_sel;
`endif
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk1x) begin
    if (rst) begin
      hs1        <= 1'b0;
      vs1        <= 1'b0;
      act1       <= 1'b0;
      rd_fifo_en <= 1'b0;
    end else begin
      hs1        <= hs;
      vs1        <= vs;
      act1       <= act;
`ifdef TEST_PATTERN_EN
      rd_fifo_en <= act && !pat_mode;
`else
      rd_fifo_en <= act;
`endif
    end
  end

  // An empty FIFO during a pop yields a black pixel, de stays high
  always_ff @(posedge clk1x) begin
    if (rst) begin
      po_de     <= 1'b0;
      po_h_sync <= ~HS_ON;
      po_v_sync <= ~VS_ON;
      rgb       <= '0;
    end else begin
      po_de     <= act1;
      po_h_sync <= hs1 ? HS_ON : ~HS_ON;
      po_v_sync <= vs1 ? VS_ON : ~VS_ON;
      if (!act1) begin
        rgb <= '0;
`ifdef TEST_PATTERN_EN
      end else if (pat_mode) begin
        rgb <= {{COLOR_W{bar_c[2]}},
                {COLOR_W{bar_c[1]}},
                {COLOR_W{bar_c[0]}}};
`endif
      end else if (fifo_empty) begin
        rgb <= '0;
      end else begin
        rgb <= rgb_pixel;
      end
    end
  end

  always_ff @(posedge clk1x) begin
    if (rst) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else if (rd_fifo_en && fifo_empty) begin
      underflow <= 1'b1;
      if (underflow_cnt != 16'hFFFF) begin
        underflow_cnt <= underflow_cnt + 16'd1;
      end
    end
  end

  assign po_vga_r = rgb[3*COLOR_W-1:2*COLOR_W];
  assign po_vga_g = rgb[2*COLOR_W-1:COLOR_W];
  assign po_vga_b = rgb[COLOR_W-1:0];

endmodule

// File: tb/tb_vid_timing_gen.sv
// Directed bench for vid_timing_gen in a 14x7 mode (H 2/2/8/2, V 1/1/4/1).
// A second instance checks inverted sync polarity; TEST_PATTERN_EN adds a bar test.
module tb_vid_timing_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        fifo_empty;
  logic [15:0] fval;
  logic [23:0] rgb_pixel;
`ifdef TEST_PATTERN_EN
  logic        pat_sel;
`endif

  logic        rd_start, rd_fifo_en, de, hs, vs, uf;
  logic [7:0]  r, g, b;
  logic [15:0] ufc;
  logic        n_rd_start, n_rd_fifo_en, n_de, nhs, nvs, n_uf;
  logic [7:0]  nr, ng, nb;
  logic [15:0] n_ufc;

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  assign rgb_pixel = {8'd0, fval};

  always_ff @(posedge clk) begin
    if (rst) fval <= 16'd1;
    else if (rd_fifo_en && !fifo_empty) fval <= fval + 16'd1;
  end

  vid_timing_gen #(
    .H_SYNC(2), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
    .HS_POL(1), .VS_POL(1), .COLOR_W(8), .CNT_W(12)
  ) dut (
    .clk1x(clk), .rst(rst), .en(en),
    .rgb_pixel(rgb_pixel), .fifo_empty(fifo_empty),
`ifdef TEST_PATTERN_EN
    .pat_sel(pat_sel),
`endif
    .rd_start(rd_start), .rd_fifo_en(rd_fifo_en),
    .po_vga_r(r), .po_vga_g(g), .po_vga_b(b),
    .po_de(de), .po_h_sync(hs), .po_v_sync(vs),
    .underflow(uf), .underflow_cnt(ufc)
  );

  vid_timing_gen #(
    .H_SYNC(2), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
    .HS_POL(0), .VS_POL(0), .COLOR_W(8), .CNT_W(12)
  ) dut_n (
    .clk1x(clk), .rst(rst), .en(en),
    .rgb_pixel(rgb_pixel), .fifo_empty(fifo_empty),
`ifdef TEST_PATTERN_EN
    .pat_sel(pat_sel),
`endif
    .rd_start(n_rd_start), .rd_fifo_en(n_rd_fifo_en),
    .po_vga_r(nr), .po_vga_g(ng), .po_vga_b(nb),
    .po_de(n_de), .po_h_sync(nhs), .po_v_sync(nvs),
    .underflow(n_uf), .underflow_cnt(n_ufc)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; fifo_empty = 1'b0;
`ifdef TEST_PATTERN_EN
    pat_sel = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; fifo_empty = 1'b0;
`ifdef TEST_PATTERN_EN
    pat_sel = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    vec++; if (rd_start !== 1'b0) begin miss++; $display("FAIL rst_rd_start got %b want 0", rd_start); end
    vec++; if (rd_fifo_en !== 1'b0) begin miss++; $display("FAIL rst_rd_fifo_en got %b want 0", rd_fifo_en); end
    vec++; if (de !== 1'b0) begin miss++; $display("FAIL rst_de got %b want 0", de); end
    vec++; if ({r, g, b} !== 24'h0) begin miss++; $display("FAIL rst_rgb got %h want 0", {r, g, b}); end
    vec++; if (hs !== 1'b0) begin miss++; $display("FAIL rst_hs got %b want 0", hs); end
    vec++; if (vs !== 1'b0) begin miss++; $display("FAIL rst_vs got %b want 0", vs); end
    vec++; if (uf !== 1'b0) begin miss++; $display("FAIL rst_uf got %b want 0", uf); end
    vec++; if (ufc !== 16'd0) begin miss++; $display("FAIL rst_ufc got %0d want 0", ufc); end
    vec++; if (nhs !== 1'b1) begin miss++; $display("FAIL rst_nhs got %b want 1", nhs); end
    vec++; if (nvs !== 1'b1) begin miss++; $display("FAIL rst_nvs got %b want 1", nvs); end
    rst = 1'b0; en = 1'b0;
    repeat (4) @(negedge clk);
    vec++; if ({rd_start, rd_fifo_en, hs, vs} !== 4'b0) begin
      miss++; $display("FAIL idle_quiet got %b want 0000", {rd_start, rd_fifo_en, hs, vs});
    end
  endtask

  task automatic test_one_frame();
    int n_start, n_rd, n_de, lag_err, runs, bad_run, run_len;
    int n_hs, n_vs, n_nhs, n_nvs, seq_err, blank_err;
    logic prev_rd;
    logic [23:0] exp_px;
    n_start = 0; n_rd = 0; n_de = 0; lag_err = 0; runs = 0; bad_run = 0;
    run_len = 0; n_hs = 0; n_vs = 0; n_nhs = 0; n_nvs = 0;
    seq_err = 0; blank_err = 0; prev_rd = 1'b0; exp_px = 24'd1;
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 110; k++) begin
      @(negedge clk);
      if (k == 0) begin
        vec++; if (rd_start !== 1'b1) begin miss++; $display("FAIL frame_rd_start_k0 got %b want 1", rd_start); end
      end
      if (k == 1) begin
        vec++; if (hs !== 1'b0) begin miss++; $display("FAIL frame_hs_k1 got %b want 0", hs); end
        en = 1'b0;
      end
      if (k == 2) begin
        vec++; if (hs !== 1'b1) begin miss++; $display("FAIL frame_hs_k2 got %b want 1", hs); end
      end
      n_start += int'(rd_start);
      n_rd    += int'(rd_fifo_en);
      n_hs    += int'(hs);
      n_vs    += int'(vs);
      n_nhs   += int'(!nhs);
      n_nvs   += int'(!nvs);
      if (de !== prev_rd) lag_err++;
      prev_rd = rd_fifo_en;
      if (de) begin
        n_de++; run_len++;
        if ({r, g, b} !== exp_px) seq_err++;
        exp_px++;
      end else begin
        if ({r, g, b} !== 24'h0) blank_err++;
        if (run_len != 0) begin
          runs++;
          if (run_len != 8) bad_run++;
          run_len = 0;
        end
      end
    end
    vec++; if (n_start != 1) begin miss++; $display("FAIL frame_starts got %0d want 1", n_start); end
    vec++; if (n_rd != 32) begin miss++; $display("FAIL frame_rd_cnt got %0d want 32", n_rd); end
    vec++; if (n_de != 32) begin miss++; $display("FAIL frame_de_cnt got %0d want 32", n_de); end
    vec++; if (lag_err != 0) begin miss++; $display("FAIL frame_de_lag got %0d errs want 0", lag_err); end
    vec++; if (runs != 4) begin miss++; $display("FAIL frame_de_lines got %0d want 4", runs); end
    vec++; if (bad_run != 0) begin miss++; $display("FAIL frame_de_width got %0d bad want 0", bad_run); end
    vec++; if (seq_err != 0) begin miss++; $display("FAIL frame_rgb_seq got %0d errs want 0", seq_err); end
    vec++; if (blank_err != 0) begin miss++; $display("FAIL frame_rgb_blank got %0d errs want 0", blank_err); end
    vec++; if (n_hs != 14) begin miss++; $display("FAIL frame_hs_cycles got %0d want 14", n_hs); end
    vec++; if (n_vs != 14) begin miss++; $display("FAIL frame_vs_cycles got %0d want 14", n_vs); end
    vec++; if (n_nhs != 14) begin miss++; $display("FAIL pol_hs_low got %0d want 14", n_nhs); end
    vec++; if (n_nvs != 14) begin miss++; $display("FAIL pol_vs_low got %0d want 14", n_nvs); end
  endtask

  task automatic test_underflow();
    logic [23:0] px [32];
    int n_de, n_black;
    n_de = 0; n_black = 0;
    for (int i = 0; i < 32; i++) px[i] = 24'hFFFFFF;
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 110; k++) begin
      @(negedge clk);
      if (k == 1) en = 1'b0;
      if (k == 33) begin
        vec++; if (uf !== 1'b0) begin miss++; $display("FAIL uf_before got %b want 0", uf); end
      end
      if (k == 34) begin
        vec++; if (rd_fifo_en !== 1'b1) begin miss++; $display("FAIL uf_pop_k34 got %b want 1", rd_fifo_en); end
      end
      if (k == 35) begin
        vec++; if (uf !== 1'b1) begin miss++; $display("FAIL uf_set got %b want 1", uf); end
      end
      if (k == 36) begin
        vec++; if (ufc !== 16'd2) begin miss++; $display("FAIL uf_cnt_k36 got %0d want 2", ufc); end
      end
      if (de) begin
        if (n_de < 32) px[n_de] = {r, g, b};
        if ({r, g, b} === 24'h0) n_black++;
        n_de++;
      end
      if (k >= 34 && k <= 36) fifo_empty = 1'b1;
      if (k == 37) fifo_empty = 1'b0;
    end
    vec++; if (n_de != 32) begin miss++; $display("FAIL uf_de_cnt got %0d want 32", n_de); end
    vec++; if (n_black != 3) begin miss++; $display("FAIL uf_black_cnt got %0d want 3", n_black); end
    vec++; if (px[0] !== 24'd1) begin miss++; $display("FAIL uf_px0 got %0d want 1", px[0]); end
    vec++; if ((px[1] | px[2] | px[3]) !== 24'd0) begin
      miss++; $display("FAIL uf_px1_3 got %h %h %h want 0", px[1], px[2], px[3]);
    end
    vec++; if (px[4] !== 24'd2) begin miss++; $display("FAIL uf_px4 got %0d want 2", px[4]); end
    vec++; if (px[31] !== 24'd29) begin miss++; $display("FAIL uf_px31 got %0d want 29", px[31]); end
    vec++; if (uf !== 1'b1) begin miss++; $display("FAIL uf_sticky got %b want 1", uf); end
    vec++; if (ufc !== 16'd3) begin miss++; $display("FAIL uf_cnt_final got %0d want 3", ufc); end
  endtask

  // Runs straight after test_underflow so the sticky flags are still set
  task automatic test_rst_mid();
    int n_rd;
    n_rd = 0;
    en = 1'b1;
    for (int k = 0; k < 49; k++) begin
      @(negedge clk);
      if (k == 47) begin
        vec++; if (rd_fifo_en !== 1'b1) begin miss++; $display("FAIL rstm_pre_rd got %b want 1", rd_fifo_en); end
        rst = 1'b1;
      end
      if (k == 48) begin
        vec++; if ({rd_start, rd_fifo_en, de, hs, vs} !== 5'b0) begin
          miss++; $display("FAIL rstm_ctrl got %b want 00000", {rd_start, rd_fifo_en, de, hs, vs});
        end
        vec++; if ({r, g, b} !== 24'h0) begin miss++; $display("FAIL rstm_rgb got %h want 0", {r, g, b}); end
        vec++; if ({nhs, nvs} !== 2'b11) begin miss++; $display("FAIL rstm_npol got %b want 11", {nhs, nvs}); end
        vec++; if ({uf, ufc} !== 17'd0) begin miss++; $display("FAIL rstm_uf got %b/%0d want 0/0", uf, ufc); end
        rst = 1'b0;
      end
    end
    for (int j = 0; j < 110; j++) begin
      @(negedge clk);
      if (j == 0) begin
        vec++; if (rd_start !== 1'b1) begin miss++; $display("FAIL restart_rd_start got %b want 1", rd_start); end
      end
      if (j == 1) en = 1'b0;
      if (j == 2) begin
        vec++; if (hs !== 1'b1) begin miss++; $display("FAIL restart_hs got %b want 1", hs); end
      end
      if (j == 33) begin
        vec++; if (de !== 1'b0) begin miss++; $display("FAIL restart_de_j33 got %b want 0", de); end
      end
      if (j == 34) begin
        vec++; if (de !== 1'b1 || {r, g, b} !== 24'd1) begin
          miss++; $display("FAIL restart_first_px got de=%b rgb=%0d want de=1 rgb=1", de, {r, g, b});
        end
      end
      n_rd += int'(rd_fifo_en);
    end
    vec++; if (n_rd != 32) begin miss++; $display("FAIL restart_rd_cnt got %0d want 32", n_rd); end
  endtask

  task automatic test_en_drop();
    int n_start, n_rd, n_de, late_rd, late_hs, seq_err;
    logic [23:0] exp_px;
    n_start = 0; n_rd = 0; n_de = 0; late_rd = 0; late_hs = 0; seq_err = 0;
    exp_px = 24'd1;
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (k == 98) begin
        vec++; if (rd_start !== 1'b1) begin miss++; $display("FAIL b2b_rd_start_k98 got %b want 1", rd_start); end
      end
      if (k == 126) en = 1'b0;
      n_start += int'(rd_start);
      n_rd    += int'(rd_fifo_en);
      if (k >= 196 && rd_fifo_en) late_rd++;
      if (k >= 198 && hs) late_hs++;
      if (de) begin
        n_de++;
        if ({r, g, b} !== exp_px) seq_err++;
        exp_px++;
      end
    end
    vec++; if (n_start != 2) begin miss++; $display("FAIL drop_starts got %0d want 2", n_start); end
    vec++; if (n_rd != 64) begin miss++; $display("FAIL drop_rd_cnt got %0d want 64", n_rd); end
    vec++; if (n_de != 64) begin miss++; $display("FAIL drop_de_cnt got %0d want 64", n_de); end
    vec++; if (late_rd != 0) begin miss++; $display("FAIL drop_late_rd got %0d want 0", late_rd); end
    vec++; if (late_hs != 0) begin miss++; $display("FAIL drop_late_hs got %0d want 0", late_hs); end
    vec++; if (seq_err != 0) begin miss++; $display("FAIL drop_rgb_seq got %0d errs want 0", seq_err); end
  endtask

`ifdef TEST_PATTERN_EN
  task automatic test_pattern();
    logic [23:0] bars [8];
    int n_rd, n_de, col_err, pos;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    n_rd = 0; n_de = 0; col_err = 0; pos = 0;
    do_reset();
    pat_sel = 1'b1; fifo_empty = 1'b1; en = 1'b1;
    for (int k = 0; k < 110; k++) begin
      @(negedge clk);
      if (k == 1) en = 1'b0;
      if (k == 34) begin
        vec++; if ({r, g, b} !== 24'hFFFFFF) begin miss++; $display("FAIL pat_first got %h want ffffff", {r, g, b}); end
      end
      if (k == 41) begin
        vec++; if ({de, r, g, b} !== 25'h1000000) begin
          miss++; $display("FAIL pat_last got de=%b rgb=%h want de=1 rgb=0", de, {r, g, b});
        end
      end
      n_rd += int'(rd_fifo_en);
      if (de) begin
        n_de++;
        if ({r, g, b} !== bars[pos]) col_err++;
        pos = (pos + 1) % 8;
      end
    end
    vec++; if (n_rd != 0) begin miss++; $display("FAIL pat_rd_cnt got %0d want 0", n_rd); end
    vec++; if (n_de != 32) begin miss++; $display("FAIL pat_de_cnt got %0d want 32", n_de); end
    vec++; if (col_err != 0) begin miss++; $display("FAIL pat_colours got %0d errs want 0", col_err); end
    vec++; if (uf !== 1'b0) begin miss++; $display("FAIL pat_no_uf got %b want 0", uf); end
    pat_sel = 1'b0; fifo_empty = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; fifo_empty = 1'b0;
`ifdef TEST_PATTERN_EN
    pat_sel = 1'b0;
`endif
    test_reset();
    test_one_frame();
    test_underflow();
    test_rst_mid();
    test_en_drop();
`ifdef TEST_PATTERN_EN
    test_pattern();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
